// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM states, widths and the
// result reported for a zero divisor.
package div_pkg;

  localparam int DIV_W  = 32;
  localparam int ITER_W = 5;

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/trial_sub32.sv
// Trial subtractor: A - B formed as A + ~B + 1, so carry-out = 1 means A >= B.
module trial_sub32
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic [DIV_W-1:0] t,
  output logic             cout
);

  assign {cout, t} = {1'b0, a} + {1'b0, ~b} + {{DIV_W{1'b0}}, 1'b1};

endmodule

// File: rtl/restoring_divider32.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, results
// published on the edge that enters DONE and held until the next request.
module restoring_divider32
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t              state, state_nxt;
  logic [ITER_W-1:0]   cnt;
  logic [DIV_W-1:0]    q_r, r_r, d_r;
  logic [DIV_W-1:0]    r_shift, t, r_next, q_next;
  logic                c, take, accept, last_iter;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (state == RUN) && (cnt == ITER_W'(DIV_W - 1));

  // {R,Q} shifted left once; R[31] shifted out still forces a subtract
  assign r_shift = {r_r[DIV_W-2:0], q_r[DIV_W-1]};

  trial_sub32 u_trial (
    .a    (r_shift),
    .b    (d_r),
    .t    (t),
    .cout (c)
  );

  assign take   = r_r[DIV_W-1] | c;
  assign r_next = take ? t : r_shift;
  assign q_next = {q_r[DIV_W-2:0], take};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == ITER_W'(DIV_W - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (divisor == '0) begin
          quotient    <= DBZ_QUOTIENT;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + ITER_W'(1);
        if (last_iter) begin
          quotient  <= q_next;
          remainder <= r_next;
        end
      end
    end
  end

  // Working registers carry no reset: they are always reloaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      d_r <= divisor;
      q_r <= dividend;
      r_r <= '0;
    end else if (state == RUN) begin
      q_r <= q_next;
      r_r <= r_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider32.sv
// Self-checking bench for restoring_divider32: directed cases plus random
// operands compared against plain / and % arithmetic.
module tb_restoring_divider32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  logic [31:0] held_q = 32'd0;

  restoring_divider32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division in the current IDLE cycle and check the result.
  // m counts falling edges after the accepting rising edge.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
    logic [31:0] eq, er;
    logic        edbz;
    int          elat, m;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; edbz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; elat = 33;
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    m = 0;
    while (m < 40) begin
      @(negedge clk);
      m++;
      if (done) break;
      if (inject && m == 10) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd2;
      end else begin
        start = 1'b0;
      end
      if (m == 16) check({tag, "_run_stable_q"}, quotient, held_q);
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(m), 32'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    held_q = eq;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    run_div("d100_7", 32'd100, 32'd7, 1'b0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_div("d3_10", 32'd3, 32'd10, 1'b0);
    run_div("d0_5", 32'd0, 32'd5, 1'b0);
    run_div("d5_0", 32'd5, 32'd0, 1'b0);
    run_div("d6_3", 32'd6, 32'd3, 1'b0);
    run_div("inject", 32'd100, 32'd7, 1'b1);
    run_div("b2b", 32'hDEAD_BEEF, 32'h0001_2345, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = (i % 8 == 2) ? 32'd0 : $urandom_range(1, 65535);
        default: rb = $urandom | 32'h8000_0000;
      endcase
      run_div($sformatf("rnd%0d", i), ra, rb, 1'b0);
    end

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held_q = 32'd0;
    run_div("d50_6", 32'd50, 32'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
